// File: rtl/am_pkg.sv
// am_pkg: shared constants and the quarter-wave sine table generator for the
// AM carrier modulator datapath.
package am_pkg;

  localparam int unsigned OUT_W      = 12;            // mod_in, carrier and DAC code width
  localparam int unsigned PH_W       = 32;            // phase accumulator width
  localparam int unsigned LUT_AW     = 8;             // quarter-wave table address width
  localparam int unsigned LUT_DEPTH  = 1 << LUT_AW;
  localparam int unsigned MAG_W      = OUT_W - 1;     // unsigned carrier magnitude width
  localparam int unsigned PROD_W     = 2 * OUT_W;     // envelope x carrier product width
  localparam int unsigned ENV_OFFSET = 2048;
  localparam logic [OUT_W-1:0] DAC_MID = 12'h800;
  localparam int unsigned PIPE_LAT   = 4;

  // round(2047*sin(pi*(2k+1)/1024)) evaluated at elaboration time with a
  // Q30 fixed-point Taylor series, so the table is pure constant data.
  function automatic logic [MAG_W-1:0] qsine_entry(input int unsigned k);
    longint pi_q30;
    longint x;
    longint term;
    longint acc;
    pi_q30 = 64'sd3373259426;
    x      = (pi_q30 * longint'(2 * k + 1)) / 64'sd1024;
    term   = x;
    acc    = x;
    for (int n = 1; n <= 7; n++) begin
      term = (term * x) >>> 30;
      term = (term * x) >>> 30;
      term = term / longint'((2 * n) * (2 * n + 1));
      if ((n % 2) == 1) acc = acc - term;
      else              acc = acc + term;
    end
    return MAG_W'((acc * 64'sd2047 + (64'sd1 <<< 29)) >>> 30);
  endfunction

endpackage

// File: rtl/sine_qlut.sv
// sine_qlut: 256 x 11 synchronous quarter-wave sine ROM.
// Ports: clk, rst (async active-high), addr[7:0] table index,
//        mag[10:0] registered magnitude, one clock after addr.
module sine_qlut
  import am_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LUT_AW-1:0] addr,
  output logic [MAG_W-1:0]  mag
);

  logic [MAG_W-1:0] rom [LUT_DEPTH];

  // Constant table, one elaboration-time entry per address.
  for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_rom
    localparam logic [MAG_W-1:0] ENTRY = qsine_entry(g);
    assign rom[g] = ENTRY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mag <= '0;
    else     mag <= rom[addr];
  end

endmodule

// File: rtl/am_carrier_mod.sv
// am_carrier_mod: multiplies the envelope 2048+mod_in by a DDS sine carrier
// and emits an offset-binary DAC code.
// Ports: clk (125 MHz), rst (async active-high), pls (mod_in sample strobe),
//        mod_in[11:0] signed modulation, f_carrier[31:0] phase increment,
//        phase_clr (sync accumulator clear), dac_out[11:0] offset-binary code,
//        dac_vld (pipeline primed since reset release).
module am_carrier_mod
  import am_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             pls,
  input  logic [OUT_W-1:0] mod_in,
  input  logic [PH_W-1:0]  f_carrier,
  input  logic             phase_clr,
  output logic [OUT_W-1:0] dac_out,
  output logic             dac_vld
);

  logic [PH_W-1:0]          phase;
  logic [OUT_W-1:0]         env;
  logic [LUT_AW-1:0]        lut_addr;
  logic [MAG_W-1:0]         mag;
  logic                     sign_s1;
  logic signed [OUT_W-1:0]  car;
  logic signed [PROD_W-1:0] prod;
  logic [PIPE_LAT-1:0]      vld_sr;
  logic                     prod_lo_unused;

  // S0: phase accumulator; a clear wins over the increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            phase <= '0;
    else if (phase_clr) phase <= '0;
    else                phase <= phase + f_carrier;
  end

  // Envelope: adding 2048 to the signed sample gives its offset-binary form.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      env <= OUT_W'(ENV_OFFSET);
    else if (pls) env <= OUT_W'(ENV_OFFSET) + mod_in;
  end

  // Quadrant fold: odd quadrants read the quarter table backwards.
  always_comb begin
    lut_addr = phase[PH_W-3 -: LUT_AW];
    if (phase[PH_W-2]) lut_addr = ~phase[PH_W-3 -: LUT_AW];
  end

  // S1: table read, with the half-wave sign travelling alongside.
  sine_qlut u_qlut (
    .clk  (clk),
    .rst  (rst),
    .addr (lut_addr),
    .mag  (mag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sign_s1 <= 1'b0;
    else     sign_s1 <= phase[PH_W-1];
  end

  // S2: signed carrier, S3: envelope product, S4: floor /4096 to offset binary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      car     <= '0;
      prod    <= '0;
      dac_out <= DAC_MID;
    end else begin
      car     <= sign_s1 ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
      prod    <= $signed({{(PROD_W-OUT_W){1'b0}}, env})
               * $signed({{(PROD_W-OUT_W){car[OUT_W-1]}}, car});
      dac_out <= {~prod[PROD_W-1], prod[PROD_W-2 -: OUT_W-1]};
    end
  end

  // Fraction bits are dropped by the truncating shift.
  assign prod_lo_unused = ^prod[OUT_W-1:0];

  // Valid flag: ones shift in behind reset release, one per pipeline stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_sr <= '0;
    else     vld_sr <= {vld_sr[PIPE_LAT-2:0], 1'b1};
  end

  assign dac_vld = vld_sr[PIPE_LAT-1];

endmodule

// File: tb/tb_am_carrier_mod.sv
// Scoreboard bench for am_carrier_mod: a driver updates an angle-based
// reference model at every edge and queues the expected DAC code; a monitor
// pops and compares on the falling edge.
module tb_am_carrier_mod;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pls = 1'b0;
  logic        phase_clr = 1'b0;
  logic [11:0] mod_in = '0;
  logic [31:0] f_carrier = '0;
  logic [11:0] dac_out;
  logic        dac_vld;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int edge_n;
    bit vld;
    int dac;
  } exp_t;

  exp_t   exp_q[$];
  longint ph_h[$];
  longint env_h[$];
  int     n_edge = 0;

  localparam logic [31:0] F_1MHZ = 32'd34359738;

  am_carrier_mod dut (
    .clk       (clk),
    .rst       (rst),
    .pls       (pls),
    .mod_in    (mod_in),
    .f_carrier (f_carrier),
    .phase_clr (phase_clr),
    .dac_out   (dac_out),
    .dac_vld   (dac_vld)
  );

  always #4 clk = ~clk;

  // Ideal sample: carrier taken at the centre of the 1/1024-turn bin.
  function automatic int ref_dac(input longint ph, input longint env);
    real    ang;
    real    s;
    longint car;
    longint prod;
    ang  = 2.0 * 3.14159265358979 * (real'(ph >> 22) + 0.5) / 1024.0;
    s    = 2047.0 * $sin(ang);
    car  = (s >= 0.0) ? longint'($rtoi(s + 0.5)) : -longint'($rtoi(0.5 - s));
    prod = env * car;
    return int'((prod >>> 12) + 64'sd2048);
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic check_tol(input string name, input int act, input int exp_v, input int tol);
    checks++;
    if (act < exp_v - tol || act > exp_v + tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d +/-%0d", name, act, exp_v, tol);
    end
  endtask

  // Reference model step for the edge that just sampled the current inputs.
  task automatic model_edge();
    longint ph;
    longint env;
    exp_t   e;
    n_edge++;
    ph  = phase_clr ? 64'sd0 : ((ph_h[$] + longint'(f_carrier)) & 64'hFFFF_FFFF);
    env = pls ? (64'sd2048 + longint'($signed(mod_in))) : env_h[$];
    ph_h.push_back(ph);
    env_h.push_back(env);
    e.edge_n = n_edge;
    e.vld    = (n_edge >= 4);
    e.dac    = e.vld ? ref_dac(ph_h[n_edge-4], env_h[n_edge-2]) : 0;
    exp_q.push_back(e);
  endtask

  task automatic tick(input logic clr, input logic [31:0] f, input logic p, input logic [11:0] m);
    phase_clr = clr;
    f_carrier = f;
    pls       = p;
    mod_in    = m;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    ph_h.delete();
    env_h.delete();
    ph_h.push_back(64'sd0);
    env_h.push_back(64'sd2048);
    n_edge = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic random_run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick(($urandom_range(0, 49) == 0), $urandom(), ($urandom_range(0, 99) < 3), 12'($urandom()));
    end
  endtask

  task automatic check_vld_rise();
    for (int i = 1; i <= 6; i++) begin
      tick(1'b0, 32'h0100_0000, 1'b0, 12'd0);
      if (i == 3) check("vld_edge3", int'(dac_vld), 0);
      if (i == 4) check("vld_edge4", int'(dac_vld), 1);
    end
  endtask

  // Monitor: one expected entry per post-reset edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (exp_q.size() == 0) begin
          if (dac_vld) check("vld_without_expectation", int'(dac_vld), 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("dac_vld@edge%0d", e.edge_n), int'(dac_vld), int'(e.vld));
          if (e.vld) check($sformatf("dac_out@edge%0d", e.edge_n), int'(dac_out), e.dac);
        end
      end
    end
  end

  initial begin
    int pat[4];
    int mx;
    int mn;
    int cur;
    int prev;
    int last_up;
    int period;

    do_reset();
    check("reset_dac_out", int'(dac_out), 2048);
    check_vld_rise();

    // Static phase 0, envelope 2048: car=6, 2048*6>>12 = 3.
    tick(1'b1, 32'd0, 1'b1, 12'd0);
    repeat (6) tick(1'b1, 32'd0, 1'b0, 12'd0);
    check("static_mid_env", int'(dac_out), 2051);

    // Quadrant sweep, env 4095: floor(4095*{6,2047,-6,-2047}/4096) + 2048.
    pat = '{2053, 4094, 2042, 1};
    tick(1'b1, 32'h4000_0000, 1'b1, 12'd2047);
    for (int i = 1; i <= 11; i++) begin
      tick(1'b0, 32'h4000_0000, 1'b0, 12'd0);
      if (i >= 4) check($sformatf("quadrant_%0d", i), int'(dac_out), pat[(i - 4) % 4]);
    end

    // Zero envelope: constant mid-code from two edges after the strobe.
    tick(1'b0, $urandom(), 1'b1, 12'h800);
    for (int i = 1; i <= 10; i++) begin
      tick(1'b0, $urandom(), 1'b0, 12'd0);
      if (i >= 2) check($sformatf("zero_env_%0d", i), int'(dac_out), 2048);
    end

    // 1 MHz carrier at env 2048, then env 3072.
    tick(1'b0, F_1MHZ, 1'b1, 12'd0);
    mx = 0; mn = 4095; prev = 4095; last_up = -1; period = 0;
    for (int i = 1; i <= 300; i++) begin
      tick(1'b0, F_1MHZ, 1'b0, 12'd0);
      if (i > 4) begin
        cur = int'(dac_out);
        if (cur > mx) mx = cur;
        if (cur < mn) mn = cur;
        if (prev < 2048 && cur >= 2048) begin
          if (last_up >= 0) period = i - last_up;
          last_up = i;
        end
        prev = cur;
      end
    end
    check_tol("peak_1mhz", mx, 3071, 1);
    check_tol("trough_1mhz", mn, 1024, 1);
    check_tol("period_1mhz", period, 125, 1);
    tick(1'b0, F_1MHZ, 1'b1, 12'd1024);
    mx = 0;
    for (int i = 1; i <= 300; i++) begin
      tick(1'b0, F_1MHZ, 1'b0, 12'd0);
      if (i > 4 && int'(dac_out) > mx) mx = int'(dac_out);
    end
    check_tol("peak_1mhz_env3072", mx, 3583, 2);

    // Clear and strobe on one edge with an all-ones increment.
    tick(1'b1, 32'hFFFF_FFFF, 1'b1, 12'd0);
    for (int i = 1; i <= 7; i++) begin
      tick(1'b0, 32'hFFFF_FFFF, 1'b0, 12'd0);
      if (i == 4) check("wrap_phase0", int'(dac_out), 2051);
      if (i >= 5) check($sformatf("wrap_q3_%0d", i), int'(dac_out), 2045);
    end

    random_run(1500);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_dac_out", int'(dac_out), 2048);
    check("async_rst_dac_vld", int'(dac_vld), 0);
    do_reset();
    check_vld_rise();

    random_run(500);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
